fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_next_state.sv | 81 ++++++++
 rtl/fifo_param.sv | 122 ++++++++++++
 tb/tb_fifo_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised FIFO.
//
// Contents:
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default word width and address width
//   state_t                         : FSM state encoding
//   fifo_depth()                    : DEPTH derived from the address width
//
// Build option: FIFO_SIMUL_RW_EN adds the RW state, where a read and a write
// share one edge.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 3;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
`ifdef FIFO_SIMUL_RW_EN
    ,
    RW       = 3'b110
`endif
  } state_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_next_state.sv
// Combinational next-state logic for fifo_param.
//
// Ports:
//   state      : current FSM state
//   wr_en      : write request
//   rd_en      : read request
//   data_count : stored word count, 0..DEPTH
//   next_state : state to register on the next clock edge
//   wr_err_x   : write rejected as a side effect of a combined request
//   rd_err_x   : read rejected as a side effect of a combined request
//
// Build option: FIFO_SIMUL_RW_EN resolves wr_en & rd_en into RW / WRITE /
// READ; without it a combined request is a NO_OP.
module fifo_next_state
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  state_t                state,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   data_count,
  output state_t                next_state,
  output logic                  wr_err_x,
  output logic                  rd_err_x
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(fifo_depth(ADDR_WIDTH));

  logic full;
  logic empty;
  logic state_ok;

  assign full  = (data_count == DEPTH_CNT);
  assign empty = (data_count == '0);

  always_comb begin
    state_ok = 1'b0;
    case (state)
      INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR: state_ok = 1'b1;
`ifdef FIFO_SIMUL_RW_EN
      RW: state_ok = 1'b1;
`endif
      default: state_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state = NO_OP;
    wr_err_x   = 1'b0;
    rd_err_x   = 1'b0;
    if (!state_ok) begin
      // Unknown encodings fall back to INIT regardless of the requests.
      next_state = INIT;
    end else begin
      case ({wr_en, rd_en})
        2'b00: next_state = (state == INIT) ? INIT : NO_OP;
        2'b10: next_state = full  ? WR_ERROR : WRITE;
        2'b01: next_state = empty ? RD_ERROR : READ;
        default: begin
`ifdef FIFO_SIMUL_RW_EN
          // The side that cannot proceed reports an error while the other
          // side completes normally.
          if (empty) begin
            next_state = WRITE;
            rd_err_x   = 1'b1;
          end else if (full) begin
            next_state = READ;
            wr_err_x   = 1'b1;
          end else begin
            next_state = RW;
          end
`else
          next_state = NO_OP;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with registered handshake results.
//
// Parameters:
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : log2 of the depth (DEPTH = 2**ADDR_WIDTH)
//
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   wr_en      : write request
//   rd_en      : read request
//   din        : write data
//   dout       : registered read data, holds between reads
//   data_count : stored word count, 0..DEPTH
//   full/empty : data_count == DEPTH / data_count == 0
//   wr_ack     : write accepted in the current state
//   wr_err     : write rejected in the current state
//   rd_ack     : read accepted in the current state
//   rd_err     : read rejected in the current state
//
// Build option: FIFO_SIMUL_RW_EN enables simultaneous read and write.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int unsigned         DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state_q;
  state_t                  next_state;
  logic                    wr_err_x;
  logic                    rd_err_x;
  logic                    do_rw;
  logic                    do_wr;
  logic                    do_rd;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  fifo_next_state #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_state (
    .state      (state_q),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .data_count (data_count),
    .next_state (next_state),
    .wr_err_x   (wr_err_x),
    .rd_err_x   (rd_err_x)
  );

`ifdef FIFO_SIMUL_RW_EN
  assign do_rw = (next_state == RW);
`else
  assign do_rw = 1'b0;
`endif

  // Data movement happens on the edge that enters the operation state.
  assign do_wr = (next_state == WRITE) || do_rw;
  assign do_rd = (next_state == READ)  || do_rw;

  assign full  = (data_count == DEPTH_CNT);
  assign empty = (data_count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state_q <= next_state;
      wr_ack  <= do_wr;
      rd_ack  <= do_rd;
      wr_err  <= (next_state == WR_ERROR) || wr_err_x;
      rd_err  <= (next_state == RD_ERROR) || rd_err_x;
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_wr && !do_rd) begin
        data_count <= data_count + 1'b1;
      end else if (do_rd && !do_wr) begin
        data_count <= data_count - 1'b1;
      end
    end
  end

  // Storage is not reset; the reset_n gate keeps an edge during reset from
  // committing a write that the reset discards.
  always_ff @(posedge clk) begin
    if (reset_n && do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default parameters.
module tb_fifo_param;
  import fifo_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fifo_param #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hs(input string tag, input logic wa, input logic we,
                        input logic ra, input logic re);
    chk({tag, ".wr_ack"}, 64'(wr_ack), 64'(wa));
    chk({tag, ".wr_err"}, 64'(wr_err), 64'(we));
    chk({tag, ".rd_ack"}, 64'(rd_ack), 64'(ra));
    chk({tag, ".rd_err"}, 64'(rd_err), 64'(re));
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    #12;
    chk("rst.count", 64'(data_count), 64'd0);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.full",  64'(full),  64'd0);
    chk("rst.dout",  64'(dout),  64'd0);
    chk("rst.state", 64'(dut.state_q), 64'(INIT));
    chk_hs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    reset_n = 1'b1;

    // Fill with 0x11..0x88.
    for (int unsigned i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 32'(i * 32'h11));
      chk("fill.wr_ack", 64'(wr_ack), 64'd1);
      chk("fill.count",  64'(data_count), 64'(i));
    end
    chk("fill.full", 64'(full), 64'd1);
    step(1'b1, 1'b0, 32'h99);
    chk_hs("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf.count", 64'(data_count), 64'd8);
    chk("ovf.state", 64'(dut.state_q), 64'(WR_ERROR));

    // Drain in order.
    for (int unsigned i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 32'h0);
      chk("drain.rd_ack", 64'(rd_ack), 64'd1);
      chk("drain.dout",   64'(dout), 64'(i * 32'h11));
      chk("drain.count",  64'(data_count), 64'(8 - i));
    end
    chk("drain.empty", 64'(empty), 64'd1);
    step(1'b0, 1'b1, 32'h0);
    chk_hs("udf", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("udf.dout",  64'(dout), 64'h88);
    chk("udf.count", 64'(data_count), 64'd0);

    step(1'b0, 1'b0, 32'h0);
    chk("idle.state", 64'(dut.state_q), 64'(NO_OP));
    chk_hs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap: 5 in/out leaves pointers at 5, then 6 in/out crosses slot 7->0.
    for (int unsigned i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i));
    for (int unsigned i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 32'h0);
      chk("wrap5.dout", 64'(dout), 64'(32'hA0 + 32'(i)));
    end
    for (int unsigned i = 1; i <= 6; i++) step(1'b1, 1'b0, 32'hB0 + 32'(i));
    chk("wrap6.count", 64'(data_count), 64'd6);
    for (int unsigned i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, 32'h0);
      chk("wrap6.dout", 64'(dout), 64'(32'hB0 + 32'(i)));
    end
    chk("wrap.count", 64'(data_count), 64'd0);
    chk("wrap.empty", 64'(empty), 64'd1);

    // Combined request at count 3.
    for (int unsigned i = 1; i <= 3; i++) step(1'b1, 1'b0, 32'hC0 + 32'(i));
    step(1'b1, 1'b1, 32'hC4);
    chk("both.count", 64'(data_count), 64'd3);
`ifdef FIFO_SIMUL_RW_EN
    chk("both.state", 64'(dut.state_q), 64'(RW));
    chk_hs("both", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("both.dout", 64'(dout), 64'hC1);
`else
    chk("both.state", 64'(dut.state_q), 64'(NO_OP));
    chk_hs("both", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("both.dout", 64'(dout), 64'hB6);
`endif
    step(1'b1, 1'b0, 32'hC5);
    chk("burst.count", 64'(data_count), 64'd4);

    // Reset between edges while a write is requested.
    wr_en = 1'b1;
    din   = 32'hD0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.count", 64'(data_count), 64'd0);
    chk("mid.empty", 64'(empty), 64'd1);
    chk("mid.state", 64'(dut.state_q), 64'(INIT));
    chk_hs("mid", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("midhold.count", 64'(data_count), 64'd0);
    chk_hs("midhold", 1'b0, 1'b0, 1'b0, 1'b0);
    wr_en = 1'b0;
    #2;
    reset_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    chk("post.state", 64'(dut.state_q), 64'(INIT));
    chk_hs("post", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hE1);
    chk("post.wr_ack", 64'(wr_ack), 64'd1);
    chk("post.count",  64'(data_count), 64'd1);
    step(1'b0, 1'b1, 32'h0);
    chk("post.dout",  64'(dout), 64'hE1);
    chk("post.count0", 64'(data_count), 64'd0);

`ifdef FIFO_SIMUL_RW_EN
    // Combined request at the empty and full boundaries.
    step(1'b1, 1'b1, 32'hF0);
    chk("bothE.state", 64'(dut.state_q), 64'(WRITE));
    chk_hs("bothE", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("bothE.count", 64'(data_count), 64'd1);
    for (int unsigned i = 1; i <= 7; i++) step(1'b1, 1'b0, 32'hF0 + 32'(i));
    chk("bothF.full", 64'(full), 64'd1);
    step(1'b1, 1'b1, 32'hFF);
    chk("bothF.state", 64'(dut.state_q), 64'(READ));
    chk_hs("bothF", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bothF.dout",  64'(dout), 64'hF0);
    chk("bothF.count", 64'(data_count), 64'd7);
`endif

    step(1'b0, 1'b0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
